// File: rtl/sram_sp_mask_ext.sv
// sram_sp_mask_ext: single-port synchronous SRAM with per-lane write mask and post-reset zero sweep.
// Latency: an accepted read returns data RD_LAT cycles later (1..3); writes land on the accepting edge.
// Backpressure: RW0_ready is low during reset and during the sweep; requests seen then are dropped, no rvalid.
//
// Ports: RW0_clk/RW0_rst_n (async active-low); request RW0_en/RW0_wmode/RW0_addr/RW0_wmask/RW0_wdata/RW0_pinj;
// response RW0_rdata/RW0_rvalid/RW0_perr; RW0_ready flags that requests are accepted.
// Optional macro SRAM_PARITY_EN: one even-parity bit per lane, RW0_pinj inverts it on write, RW0_perr reports it.
module sram_sp_mask_ext #(
  parameter int ADDR_W        = 11,
  parameter int DEPTH         = 2048,
  parameter int LANES         = 1,
  parameter int LANE_W        = 5,
  parameter int RD_LAT        = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                    RW0_clk,
  input  logic                    RW0_rst_n,
  input  logic [ADDR_W-1:0]       RW0_addr,
  input  logic                    RW0_en,
  input  logic                    RW0_wmode,
  input  logic [LANES-1:0]        RW0_wmask,
  input  logic [LANES*LANE_W-1:0] RW0_wdata,
  input  logic                    RW0_pinj,
  output logic                    RW0_ready,
  output logic [LANES*LANE_W-1:0] RW0_rdata,
  output logic                    RW0_rvalid,
  output logic [LANES-1:0]        RW0_perr
);

  localparam int DW    = LANES * LANE_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;

  logic             in_range;
  logic [IDX_W-1:0] req_idx;
  logic             acc_wr, acc_rd;

  // Upper address bits only matter for the range check; in-range addresses fit in IDX_W bits.
  assign in_range = ({1'b0, RW0_addr} < DEPTH_X);
  assign req_idx  = RW0_addr[IDX_W-1:0];
  assign acc_wr   = RW0_en && ready_q && RW0_wmode && in_range;
  assign acc_rd   = RW0_en && ready_q && !RW0_wmode;

  // Sweep FSM: one zero write per cycle, READY once the last entry is written.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_READY;
          cnt_d   = cnt_q;
        end
      end
      default: ;
    endcase
    // Registered so that ready is low throughout reset, even when the sweep is skipped.
    ready_d = (state_d == ST_READY);
  end

  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      state_q <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Single write port shared by the sweep and user writes (never both: user writes need ready).
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [LANES-1:0] mem_lane_we;
  logic [DW-1:0]    mem_wdata;
`ifdef SRAM_PARITY_EN
  logic [LANES-1:0] mem_wpar;
`endif

  always_comb begin
    mem_we      = acc_wr;
    mem_idx     = req_idx;
    mem_lane_we = RW0_wmask;
    mem_wdata   = RW0_wdata;
`ifdef SRAM_PARITY_EN
    for (int i = 0; i < LANES; i++) begin
      mem_wpar[i] = (^RW0_wdata[i*LANE_W +: LANE_W]) ^ RW0_pinj;
    end
`endif
    if (state_q == ST_INIT) begin
      // Entry 0 is also rewritten while reset is held; harmless since it is zeroed anyway.
      mem_we      = 1'b1;
      mem_idx     = cnt_q;
      mem_lane_we = '1;
      mem_wdata   = '0;
`ifdef SRAM_PARITY_EN
      mem_wpar    = '0;
`endif
    end
  end

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge RW0_clk) begin
    if (mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (mem_lane_we[i]) mem[mem_idx][i*LANE_W +: LANE_W] <= mem_wdata[i*LANE_W +: LANE_W];
      end
    end
  end

`ifdef SRAM_PARITY_EN
  logic [LANES-1:0] par_mem [DEPTH];

  always_ff @(posedge RW0_clk) begin
    if (mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (mem_lane_we[i]) par_mem[mem_idx][i] <= mem_wpar[i];
      end
    end
  end
`else
  logic unused_pinj;
  assign unused_pinj = RW0_pinj;
`endif

  // Array read is captured on the accepting edge; out-of-range reads return zero.
  logic [DW-1:0]    rd_word;
  logic [LANES-1:0] rd_perr;

  always_comb begin
    rd_word = in_range ? mem[req_idx] : '0;
    rd_perr = '0;
`ifdef SRAM_PARITY_EN
    if (in_range) begin
      for (int i = 0; i < LANES; i++) begin
        rd_perr[i] = (^rd_word[i*LANE_W +: LANE_W]) ^ par_mem[req_idx][i];
      end
    end
`endif
  end

  // Read pipeline: valid shifts every cycle, data only moves behind a valid so the
  // last stage holds the most recent read result between reads.
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [DW-1:0]     dat_q  [RD_LAT];
  logic [DW-1:0]     dat_d  [RD_LAT];
  logic [LANES-1:0]  perr_q [RD_LAT];
  logic [LANES-1:0]  perr_d [RD_LAT];

  always_comb begin
    vld_d  = '0;
    dat_d  = dat_q;
    perr_d = perr_q;
    vld_d[0] = acc_rd;
    if (acc_rd) begin
      dat_d[0]  = rd_word;
      perr_d[0] = rd_perr;
    end
    for (int k = 1; k < RD_LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) begin
        dat_d[k]  = dat_q[k-1];
        perr_d[k] = perr_q[k-1];
      end
    end
  end

  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        dat_q[k]  <= '0;
        perr_q[k] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      dat_q  <= dat_d;
      perr_q <= perr_d;
    end
  end

  assign RW0_ready  = ready_q;
  assign RW0_rvalid = vld_q[RD_LAT-1];
  assign RW0_rdata  = dat_q[RD_LAT-1];
  assign RW0_perr   = perr_q[RD_LAT-1];

endmodule

// File: tb/tb_sram_sp_mask_ext.sv
module tb_sram_sp_mask_ext;
  localparam int ADDR_W = 5, DEPTH = 16, LANES = 4, LANE_W = 8, RD_LAT = 3;
`ifdef SRAM_PARITY_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b1;
  logic        en = 1'b0, wmode = 1'b0, pinj = 1'b0;
  logic [4:0]  addr = '0;
  logic [3:0]  wmask = '0;
  logic [31:0] wdata = '0;
  logic        ready, rvalid;
  logic [31:0] rdata;
  logic [3:0]  perr;

  sram_sp_mask_ext #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LANES(LANES), .LANE_W(LANE_W),
                     .RD_LAT(RD_LAT), .INIT_ON_RESET(1)) dut (
    .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
    .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_pinj(pinj), .RW0_ready(ready),
    .RW0_rdata(rdata), .RW0_rvalid(rvalid), .RW0_perr(perr));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: array contents, per-lane "last write had pinj" flags,
  // cycles since reset release, and reads with the cycle they must appear on.
  typedef struct {longint due; logic [31:0] d; logic [3:0] p;} rd_t;
  logic [31:0] m_mem [DEPTH];
  logic [3:0]  m_inj [DEPTH];
  int          rel_cnt = 0;
  longint      cyc = 0;
  rd_t         q[$];
  logic [31:0] held_d = '0;
  logic [3:0]  held_p = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_cnt = 0;
      q.delete();
      held_d = '0;
      held_p = '0;
    end else begin
      logic [3:0] a4;
      a4 = addr[3:0];
      cyc++;
      if (rel_cnt < DEPTH) begin
        m_mem[rel_cnt] = '0;
        m_inj[rel_cnt] = '0;
      end else if (en) begin
        if (addr < DEPTH) begin
          if (wmode) begin
            for (int i = 0; i < LANES; i++) begin
              if (wmask[i]) begin
                m_mem[a4][i*8 +: 8] = wdata[i*8 +: 8];
                m_inj[a4][i]        = pinj;
              end
            end
          end else begin
            q.push_back('{cyc + RD_LAT - 1, m_mem[a4], PAR ? m_inj[a4] : 4'h0});
          end
        end else if (!wmode) begin
          q.push_back('{cyc + RD_LAT - 1, 32'h0, 4'h0});
        end
      end
      if (rel_cnt < DEPTH) rel_cnt++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ready", ready, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_perr", perr, 0);
    end else begin
      logic exp_v;
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      if (exp_v) begin
        held_d = q[0].d;
        held_p = q[0].p;
        void'(q.pop_front());
      end
      check("ready", ready, (rel_cnt >= DEPTH));
      check("rvalid", rvalid, exp_v);
      check("rdata", rdata, held_d);
      check("perr", perr, held_p);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m, input logic pj);
    en = 1'b1; wmode = 1'b1; addr = a; wdata = d; wmask = m; pinj = pj;
    tick();
    en = 1'b0; wmask = '0; pinj = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    en = 1'b1; wmode = 1'b0; addr = a;
    tick();
    en = 1'b0;
  endtask

  task automatic rd_chk(input logic [4:0] a, input logic [31:0] exp_d, input logic [3:0] exp_p,
                        input string name);
    rd(a);
    repeat (RD_LAT - 1) tick();
    @(negedge clk);
    check({name, "_vld"}, rvalid, 1);
    check({name, "_dat"}, rdata, exp_d);
    check({name, "_perr"}, perr, exp_p);
  endtask

  // Counts cycles with ready low, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (ready) break;
      n++;
    end
  endtask

  logic [7:0]  vbits;
  logic [31:0] dats [8];
  int          n;

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) tick();
    // First release, then a reset pulse at sweep cycle 7.
    rst_n = 1'b1;
    repeat (7) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    wr(5'd5, 32'h0000_00FF, 4'hF, 1'b0);   // dropped: sweep still running
    wait_ready(n);
    check("ready_after_pulse", 11 + n, DEPTH);

    // Init sweep: every entry reads zero.
    for (int a = 0; a < DEPTH; a++) rd(5'(a));
    repeat (RD_LAT) tick();
    rd_chk(5'd5, 32'h0, 4'h0, "dropped_wr");

    // Masked write merge.
    wr(5'd3, 32'hAABB_CCDD, 4'b1111, 1'b0);
    wr(5'd3, 32'h1122_3344, 4'b0101, 1'b0);
    rd_chk(5'd3, 32'hAA22_CC44, 4'h0, "masked");
    wr(5'd3, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    rd_chk(5'd3, 32'hAA22_CC44, 4'h0, "mask_zero");

    // Back-to-back reads, latency and hold.
    wr(5'd0, 32'h0101_0101, 4'hF, 1'b0);
    wr(5'd1, 32'h0202_0202, 4'hF, 1'b0);
    wr(5'd2, 32'h0303_0303, 4'hF, 1'b0);
    rd(5'd0); rd(5'd1); rd(5'd2);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vbits[i] = rvalid;
      dats[i]  = rdata;
    end
    check("pipe_vld", vbits, 8'b0000_0111);
    check("pipe_d0", dats[0], 32'h0101_0101);
    check("pipe_d1", dats[1], 32'h0202_0202);
    check("pipe_d2", dats[2], 32'h0303_0303);
    check("pipe_hold", dats[7], 32'h0303_0303);

    // Out-of-range: write ignored (no alias onto entry 4), read gives zero.
    wr(5'd20, 32'hDEAD_BEEF, 4'hF, 1'b0);
    rd_chk(5'd20, 32'h0, 4'h0, "oor_rd");
    rd_chk(5'd4, 32'h0, 4'h0, "oor_alias");

    // Parity inject on lane 0, normal write on lane 1.
    wr(5'd7, 32'h0000_005A, 4'b0001, 1'b1);
    wr(5'd7, 32'h0000_A500, 4'b0010, 1'b0);
    rd_chk(5'd7, 32'h0000_A55A, PAR ? 4'b0001 : 4'b0000, "parity");

    // Random traffic checked by the model every cycle.
    for (int i = 0; i < 1500; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      wmode = $urandom_range(0, 1) == 1;
      addr  = 5'($urandom_range(0, 19));
      wmask = 4'($urandom);
      wdata = $urandom;
      pinj  = ($urandom_range(0, 7) == 0);
      tick();
    end
    en = 1'b0; wmask = '0; pinj = 1'b0;
    repeat (RD_LAT + 1) tick();

    // Reset with a read in flight: no rvalid, sweep restarts.
    rd(5'd3);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    wait_ready(n);
    check("ready_after_midread", n, DEPTH);
    rd_chk(5'd3, 32'h0, 4'h0, "post_reset_zero");
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
